// File: rtl/mem_wb_buffer_if.sv
// Line req/gnt protocol used on both sides of the write buffer.
// Master drives the request and its line; slave returns the read line and a one-cycle gnt.
interface mem_wb_buffer_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

    logic [ADDR_LEN-1:0]        addr;
    logic                       rd_req;
    logic                       wr_req;
    logic [LINE_SIZE-1:0][31:0] wr_line;
    logic [LINE_SIZE-1:0][31:0] rd_line;
    logic                       gnt;

    modport master (output addr, rd_req, wr_req, wr_line, input rd_line, gnt);
    modport slave  (input addr, rd_req, wr_req, wr_line, output rd_line, gnt);
endinterface

// File: rtl/mem_wb_buffer.sv
// Write buffer between cache and memory: writes and read hits grant in 1 cycle; misses go to memory.
// Writes stall while full; read misses wait for the in-flight drain and then take priority.
module mem_wb_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 10,
    parameter int DEPTH         = 4
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_buffer_if.slave   cache,
    mem_wb_buffer_if.master  mem
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [LINE_SIZE-1:0][31:0] line_t;
    typedef logic [ADDR_LEN-1:0]        addr_t;
    typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} mstate_e;

    mstate_e          state_q, state_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    addr_t            addr_q [DEPTH];
    addr_t            addr_d [DEPTH];
    line_t            line_q [DEPTH];
    line_t            line_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             gnt_q, gnt_d;
    line_t            rd_line_q, rd_line_d;
    logic             rd_pend_q, rd_pend_d;
    addr_t            rd_addr_q, rd_addr_d;

    logic             co_hit, rd_hit, accept_ok, push, pop;
    logic [PTR_W-1:0] co_idx, scan_idx;
    line_t            rd_hit_line;

    // Scan oldest to youngest so the last match is the youngest copy.
    // The head being drained is readable but must not be overwritten.
    always_comb begin
        co_hit      = 1'b0;
        co_idx      = '0;
        rd_hit      = 1'b0;
        rd_hit_line = '0;
        scan_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (valid_q[scan_idx] && addr_q[scan_idx] == cache.addr) begin
                rd_hit      = 1'b1;
                rd_hit_line = line_q[scan_idx];
                if (!(state_q == M_WR && scan_idx == head_q)) begin
                    co_hit = 1'b1;
                    co_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        line_d    = line_q;
        head_d    = head_q;
        tail_d    = tail_q;
        gnt_d     = 1'b0;
        rd_line_d = rd_line_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        push      = 1'b0;
        pop       = 1'b0;
        accept_ok = !gnt_q && !rd_pend_q;

        if (accept_ok && cache.wr_req) begin
            if (co_hit) begin
                line_d[co_idx] = cache.wr_line;
                gnt_d          = 1'b1;
            end else if (count_q < CNT_W'(DEPTH)) begin
                push           = 1'b1;
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q] = cache.addr;
                line_d[tail_q] = cache.wr_line;
                tail_d         = tail_q + 1'b1;
                gnt_d          = 1'b1;
            end
        end else if (accept_ok && cache.rd_req) begin
            if (rd_hit) begin
                rd_line_d = rd_hit_line;
                gnt_d     = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = cache.addr;
            end
        end

        unique case (state_q)
            M_IDLE: begin
                if (rd_pend_q)           state_d = M_RD;
                else if (count_q != '0)  state_d = M_WR;
            end
            M_WR: begin
                if (mem.gnt) begin
                    pop             = 1'b1;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + 1'b1;
                    state_d         = M_IDLE;
                end
            end
            M_RD: begin
                if (mem.gnt) begin
                    rd_line_d = mem.rd_line;
                    gnt_d     = 1'b1;
                    rd_pend_d = 1'b0;
                    state_d   = M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= M_IDLE;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            gnt_q     <= 1'b0;
            rd_line_q <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                line_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            gnt_q     <= gnt_d;
            rd_line_q <= rd_line_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            line_q    <= line_d;
        end
    end

    assign cache.gnt     = gnt_q;
    assign cache.rd_line = rd_line_q;
    assign mem.wr_req    = (state_q == M_WR);
    assign mem.rd_req    = (state_q == M_RD);
    assign mem.addr      = (state_q == M_WR) ? addr_q[head_q] :
                           (state_q == M_RD) ? rd_addr_q : '0;
    assign mem.wr_line   = (state_q == M_WR) ? line_q[head_q] : '0;
endmodule
